// File: rtl/motor_frame_decoder.sv
// Byte-frame decoder: SYNC, NUM_MOTORS speed bytes, optional XOR checksum, committed atomically.
// Includes an inter-byte timeout, error pulses and a link-loss failsafe that zeroes the speeds.
module motor_frame_decoder #(
  parameter int         NUM_MOTORS   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hFF,
  parameter bit         CHK_EN       = 1'b1,
  parameter int         TIMEOUT_CYC  = 100000,
  parameter int         FAILSAFE_CYC = 5000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              serial,
  input  logic                    received,
  output logic [8*NUM_MOTORS-1:0] motor_speed,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    failsafe,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = $clog2(NUM_MOTORS) + 1;
  localparam int GAP_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int FS_W  = $clog2(FAILSAFE_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_index, w_index_nxt;
  logic [7:0]              r_acc, w_acc_nxt;
  logic [7:0]              r_shadow [NUM_MOTORS];
  logic [7:0]              w_shadow_nxt [NUM_MOTORS];
  logic [GAP_W-1:0]        r_gap, w_gap_nxt;
  logic [FS_W-1:0]         r_fs_cnt;
  logic [8*NUM_MOTORS-1:0] r_motor_speed, w_commit_vec;
  logic                    r_frame_valid, r_frame_err, r_failsafe;
  logic                    w_timeout, w_commit, w_bad_chk, w_last;

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_acc_nxt    = r_acc;
    w_shadow_nxt = r_shadow;
    w_gap_nxt    = '0;
    w_commit     = 1'b0;
    w_bad_chk    = 1'b0;
    w_timeout    = (r_state != S_IDLE) && (r_gap == GAP_W'(TIMEOUT_CYC));
    w_last       = (r_index == IDX_W'(NUM_MOTORS - 1));
    case (r_state)
      S_IDLE: begin
        if (received && serial == SYNC_BYTE) begin
          w_state_nxt = S_PAYLOAD;
          w_index_nxt = '0;
          w_acc_nxt   = '0;
        end
      end
      S_PAYLOAD: begin
        // A byte landing on the timeout cycle is dropped with the frame.
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (received) begin
          for (int k = 0; k < NUM_MOTORS; k++) begin
            if (r_index == IDX_W'(k)) w_shadow_nxt[k] = serial;
          end
          w_acc_nxt   = r_acc ^ serial;
          w_index_nxt = r_index + 1'b1;
          if (w_last) begin
            if (CHK_EN) begin
              w_state_nxt = S_CHECK;
            end else begin
              w_state_nxt = S_IDLE;
              w_commit    = 1'b1;
            end
          end
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_CHECK: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (received) begin
          w_state_nxt = S_IDLE;
          if (serial == r_acc) w_commit  = 1'b1;
          else                 w_bad_chk = 1'b1;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Built from the next shadow so the final payload byte is included when there is no checksum.
    for (int k = 0; k < NUM_MOTORS; k++) begin
      w_commit_vec[8*k +: 8] = w_shadow_nxt[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_acc   <= '0;
      r_gap   <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) r_shadow[k] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_acc    <= w_acc_nxt;
      r_gap    <= w_gap_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Commit has priority over a failsafe expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_motor_speed <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_failsafe    <= 1'b0;
      r_fs_cnt      <= '0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_err   <= w_timeout | w_bad_chk;
      if (w_commit) begin
        r_motor_speed <= w_commit_vec;
        r_failsafe    <= 1'b0;
        r_fs_cnt      <= '0;
      end else if (FAILSAFE_CYC != 0 && r_fs_cnt != FS_W'(FAILSAFE_CYC)) begin
        r_fs_cnt <= r_fs_cnt + 1'b1;
        if (r_fs_cnt == FS_W'(FAILSAFE_CYC - 1)) begin
          r_failsafe    <= 1'b1;
          r_motor_speed <= '0;
        end
      end
    end
  end

  assign motor_speed = r_motor_speed;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign failsafe    = r_failsafe;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_motor_frame_decoder.sv
// Directed bench for motor_frame_decoder: frame parsing, checksum, timeout, failsafe and reset.
module tb_motor_frame_decoder;

  localparam int NM   = 4;
  localparam int TOUT = 50;
  localparam int FS   = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    serial = '0;
  logic          received = 1'b0;
  logic [8*NM-1:0] motor_speed;
  logic          frame_valid, frame_err, failsafe, busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  motor_frame_decoder #(
    .NUM_MOTORS(NM), .SYNC_BYTE(8'hFF), .CHK_EN(1'b1),
    .TIMEOUT_CYC(TOUT), .FAILSAFE_CYC(FS)
  ) dut (
    .clk(clk), .rst(rst), .serial(serial), .received(received),
    .motor_speed(motor_speed), .frame_valid(frame_valid), .frame_err(frame_err),
    .failsafe(failsafe), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) fv_cnt++;
      if (frame_err) fe_cnt++;
      if (frame_valid && frame_err) both_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bytes are sent MSB first, one per clock.
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      serial   = v[8*(n-1-i) +: 8];
      received = 1'b1;
      @(posedge clk);
      #1;
      received = 1'b0;
    end
  endtask

  task automatic test_reset;
    idle(3);
    checks++;
    if (motor_speed !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0 ||
        failsafe !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset: speed=%h fv=%b fe=%b fs=%b busy=%b st=%0d expected all zero",
               motor_speed, frame_valid, frame_err, failsafe, busy, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    int fv0, fe0;
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_bytes(64'h0000_FF10_2030_4040, 6);
    idle(4);
    checks++;
    if (motor_speed !== 32'h40302010) begin
      failures++;
      $display("FAIL good_frame_speed: got %h expected 40302010", motor_speed);
    end
    checks++;
    if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
      failures++;
      $display("FAIL good_frame_pulses: fv=%0d fe=%0d expected fv=1 fe=0", fv_cnt - fv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_bad_checksum;
    int fv0, fe0;
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_bytes(64'h0000_FF01_0203_0400, 6);
    idle(4);
    checks++;
    if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
      failures++;
      $display("FAIL bad_chk_pulses: fe=%0d fv=%0d expected fe=1 fv=0", fe_cnt - fe0, fv_cnt - fv0);
    end
    checks++;
    if (motor_speed !== 32'h40302010) begin
      failures++;
      $display("FAIL bad_chk_hold: got %h expected 40302010", motor_speed);
    end
  endtask

  task automatic test_noise_then_sync;
    int fv0;
    fv0 = fv_cnt;
    send_bytes(64'h007E_FF05_0505_0500, 8);
    idle(4);
    checks++;
    if (motor_speed !== 32'h05050505 || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL noise_sync: got %h fv=%0d expected 05050505 fv=1", motor_speed, fv_cnt - fv0);
    end
  endtask

  task automatic test_sync_in_payload;
    int fv0;
    fv0 = fv_cnt;
    send_bytes(64'h0000_FFFF_0000_00FF, 6);
    idle(4);
    checks++;
    if (motor_speed !== 32'h000000FF || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL sync_payload: got %h fv=%0d expected 000000ff fv=1", motor_speed, fv_cnt - fv0);
    end
  endtask

  task automatic test_timeout;
    int fe0, fv0;
    fe0 = fe_cnt; fv0 = fv_cnt;
    send_bytes(64'h0000_0000_00FF_1122, 3);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL timeout_busy: busy=%b st=%0d expected busy=1 st=1", busy, dbg_state);
    end
    idle(TOUT - 10);
    checks++;
    if (fe_cnt - fe0 !== 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: fe=%0d busy=%b expected fe=0 busy=1", fe_cnt - fe0, busy);
    end
    idle(20);
    checks++;
    if (fe_cnt - fe0 !== 1 || busy !== 1'b0 || fv_cnt - fv0 !== 0) begin
      failures++;
      $display("FAIL timeout_fire: fe=%0d busy=%b fv=%0d expected fe=1 busy=0 fv=0",
               fe_cnt - fe0, busy, fv_cnt - fv0);
    end
    send_bytes(64'h0000_FF01_0101_0100, 6);
    idle(4);
    checks++;
    if (motor_speed !== 32'h01010101) begin
      failures++;
      $display("FAIL timeout_recover: got %h expected 01010101", motor_speed);
    end
  endtask

  task automatic test_failsafe;
    send_bytes(64'h0000_FF10_2030_4040, 6);
    idle(FS - 15);
    checks++;
    if (failsafe !== 1'b0 || motor_speed !== 32'h40302010) begin
      failures++;
      $display("FAIL failsafe_early: fs=%b speed=%h expected fs=0 speed=40302010", failsafe, motor_speed);
    end
    idle(20);
    checks++;
    if (failsafe !== 1'b1 || motor_speed !== 32'h0) begin
      failures++;
      $display("FAIL failsafe_trip: fs=%b speed=%h expected fs=1 speed=0", failsafe, motor_speed);
    end
    send_bytes(64'h0000_FF01_0101_0100, 6);
    idle(4);
    checks++;
    if (failsafe !== 1'b0 || motor_speed !== 32'h01010101) begin
      failures++;
      $display("FAIL failsafe_clear: fs=%b speed=%h expected fs=0 speed=01010101", failsafe, motor_speed);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fv0;
    send_bytes(64'h0000_0000_00FF_1234, 3);
    rst = 1'b1;
    #1;
    checks++;
    if (motor_speed !== '0 || busy !== 1'b0 || dbg_state !== 2'd0 || failsafe !== 1'b0 ||
        frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: speed=%h busy=%b st=%0d fs=%b fv=%b fe=%b expected all zero",
               motor_speed, busy, dbg_state, failsafe, frame_valid, frame_err);
    end
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    fv0 = fv_cnt;
    send_bytes(64'h0000_0000_0056_7800, 3);
    idle(4);
    checks++;
    if (fv_cnt - fv0 !== 0 || motor_speed !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: fv=%0d speed=%h busy=%b expected fv=0 speed=0 busy=0",
               fv_cnt - fv0, motor_speed, busy);
    end
    send_bytes(64'h0000_FF10_2030_4040, 6);
    idle(4);
    checks++;
    if (motor_speed !== 32'h40302010 || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL reset_recover: got %h fv=%0d expected 40302010 fv=1", motor_speed, fv_cnt - fv0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_noise_then_sync();
    test_sync_in_payload();
    test_timeout();
    test_failsafe();
    test_reset_mid_frame();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL valid_err_exclusive: overlap cycles=%0d expected 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
